// File: rtl/pll_reset_sequencer_if.sv
// pll_seq_if
//  Bundles the PLL lock input and the reset/status outputs of the
//  PLL reset sequencer.
//  Ports (by modport):
//   master : the sequencer; samples pll_locked, drives everything else
//   slave  : the PLL / clock-domain side; drives pll_locked, observes the rest
//  Signals:
//   pll_locked     PLL lock, asynchronous to clk_74a
//   pll_rst        active-high reset to the PLL
//   sdram_reset_n  SDRAM-domain reset, active low
//   cpu_reset_n    CPU-domain reset, active low
//   audio_reset_n  audio-domain reset, active low
//   ready          all domains released and lock held
//   fault          sticky fault after repeated lock timeouts
//   retry_count    lock timeouts since the last entry to RUN
//   state_dbg      current sequencer state (debug observation)
//  Handshake: there is no valid/ready pairing here; pll_locked is a level and
//  every output is a registered level that changes only on a clk_74a edge or
//  on asynchronous reset.
interface pll_seq_if;
   logic       pll_locked;
   logic       pll_rst;
   logic       sdram_reset_n;
   logic       cpu_reset_n;
   logic       audio_reset_n;
   logic       ready;
   logic       fault;
   logic [2:0] retry_count;
   logic [2:0] state_dbg;

   modport master (
      input  pll_locked,
      output pll_rst, sdram_reset_n, cpu_reset_n, audio_reset_n,
      output ready, fault, retry_count, state_dbg
   );

   modport slave (
      output pll_locked,
      input  pll_rst, sdram_reset_n, cpu_reset_n, audio_reset_n,
      input  ready, fault, retry_count, state_dbg
   );
endinterface

// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer
//  Pulses the system PLL reset, qualifies lock as stable, then releases the
//  SDRAM, CPU and audio domain resets in that order, spaced by STAGE_GAP
//  cycles. Lock timeouts re-pulse the PLL; MAX_RETRIES timeouts latch FAULT,
//  which only reset_n clears. Any lock loss after release restarts the whole
//  sequence from the PLL reset.
//  Ports:
//   clk_74a   74.25 MHz reference clock, rising edge
//   reset_n   asynchronous active-low reset
//   bus       pll_seq_if.master (lock in, PLL/domain resets and status out)
module pll_reset_sequencer #(
   parameter int PLL_RST_CYCLES = 16,
   parameter int LOCK_TIMEOUT   = 65536,
   parameter int STABLE_CYCLES  = 4096,
   parameter int STAGE_GAP      = 256,
   parameter int MAX_RETRIES    = 3
) (
   input  logic       clk_74a,
   input  logic       reset_n,
   pll_seq_if.master  bus
);

   localparam int MAX_AB  = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
   localparam int MAX_CD  = (STABLE_CYCLES > STAGE_GAP) ? STABLE_CYCLES : STAGE_GAP;
   localparam int MAX_CNT = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
   localparam int CW      = $clog2(MAX_CNT) + 1;

   localparam logic [CW-1:0] RST_LAST     = CW'(PLL_RST_CYCLES - 1);
   localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
   localparam logic [CW-1:0] STABLE_LAST  = CW'(STABLE_CYCLES - 1);
   localparam logic [CW-1:0] GAP_LAST     = CW'(STAGE_GAP - 1);
   localparam logic [2:0]    RETRY_LIMIT  = 3'(MAX_RETRIES);

   typedef enum logic [2:0] {
      S_PLL_RESET = 3'd0,
      S_WAIT_LOCK = 3'd1,
      S_STABLE    = 3'd2,
      S_REL_SDRAM = 3'd3,
      S_REL_CPU   = 3'd4,
      S_REL_AUDIO = 3'd5,
      S_RUN       = 3'd6,
      S_FAULT     = 3'd7
   } state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic [2:0]    retry, retry_nxt;
   logic          lock_meta, locked_s;

   logic pll_rst_q, sdram_q, cpu_q, audio_q, ready_q, fault_q;

   // Two-flop synchroniser for the asynchronous lock input.
   always_ff @(posedge clk_74a or negedge reset_n) begin
      if (!reset_n) begin
         lock_meta <= 1'b0;
         locked_s  <= 1'b0;
      end else begin
         lock_meta <= bus.pll_locked;
         locked_s  <= lock_meta;
      end
   end

   always_ff @(posedge clk_74a or negedge reset_n) begin
      if (!reset_n) begin
         state <= S_PLL_RESET;
         cnt   <= '0;
         retry <= 3'd0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         retry <= retry_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      retry_nxt = retry;
      cnt_nxt   = cnt + 1'b1;

      unique case (state)
         S_PLL_RESET: begin
            if (cnt == RST_LAST) state_nxt = S_WAIT_LOCK;
         end
         S_WAIT_LOCK: begin
            if (locked_s) begin
               state_nxt = S_STABLE;
            end else if (cnt == TIMEOUT_LAST) begin
               retry_nxt = retry + 3'd1;
               state_nxt = (retry_nxt == RETRY_LIMIT) ? S_FAULT : S_PLL_RESET;
            end
         end
         S_STABLE: begin
            if (!locked_s)                state_nxt = S_WAIT_LOCK;
            else if (cnt == STABLE_LAST)  state_nxt = S_REL_SDRAM;
         end
         // Lock loss is tested first so it wins over a same-cycle advance.
         S_REL_SDRAM: begin
            if (!locked_s)             state_nxt = S_PLL_RESET;
            else if (cnt == GAP_LAST)  state_nxt = S_REL_CPU;
         end
         S_REL_CPU: begin
            if (!locked_s)             state_nxt = S_PLL_RESET;
            else if (cnt == GAP_LAST)  state_nxt = S_REL_AUDIO;
         end
         S_REL_AUDIO: begin
            if (!locked_s) begin
               state_nxt = S_PLL_RESET;
            end else if (cnt == GAP_LAST) begin
               state_nxt = S_RUN;
               retry_nxt = 3'd0;
            end
         end
         S_RUN: begin
            cnt_nxt = cnt;
            if (!locked_s) state_nxt = S_PLL_RESET;
         end
         S_FAULT: begin
            cnt_nxt = cnt;
         end
         default: state_nxt = S_PLL_RESET;
      endcase

      if (state_nxt != state) cnt_nxt = '0;
   end

   // Outputs are decoded from the next state and registered, so each output
   // flop changes on the same edge as the state and never glitches.
   always_ff @(posedge clk_74a or negedge reset_n) begin
      if (!reset_n) begin
         pll_rst_q <= 1'b1;
         sdram_q   <= 1'b0;
         cpu_q     <= 1'b0;
         audio_q   <= 1'b0;
         ready_q   <= 1'b0;
         fault_q   <= 1'b0;
      end else begin
         pll_rst_q <= (state_nxt == S_PLL_RESET) || (state_nxt == S_FAULT);
         sdram_q   <= (state_nxt == S_REL_SDRAM) || (state_nxt == S_REL_CPU) ||
                      (state_nxt == S_REL_AUDIO) || (state_nxt == S_RUN);
         cpu_q     <= (state_nxt == S_REL_CPU) || (state_nxt == S_REL_AUDIO) ||
                      (state_nxt == S_RUN);
         audio_q   <= (state_nxt == S_REL_AUDIO) || (state_nxt == S_RUN);
         ready_q   <= (state_nxt == S_RUN);
         fault_q   <= (state_nxt == S_FAULT);
      end
   end

   assign bus.pll_rst       = pll_rst_q;
   assign bus.sdram_reset_n = sdram_q;
   assign bus.cpu_reset_n   = cpu_q;
   assign bus.audio_reset_n = audio_q;
   assign bus.ready         = ready_q;
   assign bus.fault         = fault_q;
   assign bus.retry_count   = retry;
   assign bus.state_dbg     = state;

endmodule
